// File: rtl/srff_driver.sv
// Purpose : driver for an srff set/reset flop; turns a raw, bouncy level into one-cycle s/r pulses.
// Latency : a stable din change before edge 1 gives lvl and the pulse after edge DEBOUNCE_CYCLES+2; state follows one edge later.
// Backpressure: none; the srff accepts a pulse every cycle, so no input is ever stalled.
//
// Ports:
//   clk     in   system clock, all logic on posedge
//   rst     in   synchronous active-high reset
//   din     in   raw asynchronous level request
//   s       out  one-cycle set pulse to the srff
//   r       out  one-cycle reset pulse to the srff
//   state   out  mirror of the srff q (one cycle after s/r)
//   lvl     out  debounced, synchronised din
//   expired out  high while a set has been auto-cleared and lvl is still high
module srff_driver #(
  parameter int unsigned DEBOUNCE_CYCLES   = 4,
  parameter int unsigned AUTO_CLEAR_CYCLES = 0,
  parameter int unsigned CNT_W             = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic s,
  output logic r,
  output logic state,
  output logic lvl,
  output logic expired
);

  // Terminal counts. When auto-clear is disabled AUTO_LAST is never used.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             AUTO_EN   = (AUTO_CLEAR_CYCLES != 0);
  localparam logic [CNT_W-1:0] AUTO_LAST = AUTO_EN ? CNT_W'(AUTO_CLEAR_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SET     = 2'd1,
    ST_EXPIRED = 2'd2
  } fsm_e;

  // Synchroniser and debounce state.
  logic             din_meta_q;
  logic             din_sync_q;
  logic             lvl_q;
  logic             lvl_d;
  logic [CNT_W-1:0] deb_cnt_q;
  logic [CNT_W-1:0] deb_cnt_d;

  // Pulse FSM state and registered outputs.
  fsm_e             fsm_q;
  logic [CNT_W-1:0] tmr_q;
  logic             s_q;
  logic             r_q;
  logic             state_q;
  logic             expired_q;

  // Edge events are taken from the debounce next-state so the pulse leaves
  // on the same edge that lvl changes, rather than one cycle later.
  logic             lvl_rise;
  logic             lvl_fall;

  // ---------------------------------------------------------------------
  // Two-flop synchroniser
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      din_meta_q <= 1'b0;
      din_sync_q <= 1'b0;
    end else begin
      din_meta_q <= din;
      din_sync_q <= din_meta_q;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce: lvl flips only after DEBOUNCE_CYCLES consecutive synchronised
  // samples disagree with it; any agreeing sample restarts the count.
  // ---------------------------------------------------------------------
  always_comb begin
    lvl_d     = lvl_q;
    deb_cnt_d = deb_cnt_q;
    if (din_sync_q == lvl_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      lvl_d     = din_sync_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      lvl_q     <= lvl_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign lvl_rise = ~lvl_q &  lvl_d;
  assign lvl_fall =  lvl_q & ~lvl_d;

  // ---------------------------------------------------------------------
  // Pulse FSM with registered outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= ST_IDLE;
      tmr_q     <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      state_q   <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      s_q <= 1'b0;
      r_q <= 1'b0;

      // Behaves exactly like the downstream srff clocked by our own pulses.
      if (s_q) begin
        state_q <= 1'b1;
      end else if (r_q) begin
        state_q <= 1'b0;
      end

      case (fsm_q)
        ST_IDLE: begin
          tmr_q <= '0;
          if (lvl_rise) begin
            s_q   <= 1'b1;
            fsm_q <= ST_SET;
          end
        end

        ST_SET: begin
          // A genuine fall wins over a coincident timeout: one r, back to idle.
          if (lvl_fall) begin
            r_q   <= 1'b1;
            tmr_q <= '0;
            fsm_q <= ST_IDLE;
          end else if (AUTO_EN && (tmr_q == AUTO_LAST)) begin
            r_q       <= 1'b1;
            tmr_q     <= '0;
            expired_q <= 1'b1;
            fsm_q     <= ST_EXPIRED;
          end else if (tmr_q != CNT_MAX) begin
            // Saturate so a long set with auto-clear off never wraps.
            tmr_q <= tmr_q + CNT_W'(1);
          end
        end

        ST_EXPIRED: begin
          // The flop was already cleared by the timeout pulse, so the
          // eventual fall only rearms; it produces no pulse.
          tmr_q <= '0;
          if (lvl_fall) begin
            expired_q <= 1'b0;
            fsm_q     <= ST_IDLE;
          end
        end

        default: begin
          tmr_q     <= '0;
          expired_q <= 1'b0;
          fsm_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign s       = s_q;
  assign r       = r_q;
  assign state   = state_q;
  assign lvl     = lvl_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_srff_driver.sv
// Purpose : self-checking bench for srff_driver, two instances (auto-clear off / 10 cycles) sharing din and rst.
// Latency : outputs sampled on the falling edge, half a cycle after the active edge.
// Backpressure: none.
module tb_srff_driver;

  localparam int D     = 4;
  localparam int AUTO1 = 10;

  logic clk;
  logic rst;
  logic din;

  logic u0_s, u0_r, u0_state, u0_lvl, u0_exp;
  logic u1_s, u1_r, u1_state, u1_lvl, u1_exp;

  int total;
  int bad;
  bit chk_en;

  srff_driver #(.DEBOUNCE_CYCLES(D), .AUTO_CLEAR_CYCLES(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .din(din),
    .s(u0_s), .r(u0_r), .state(u0_state), .lvl(u0_lvl), .expired(u0_exp)
  );

  srff_driver #(.DEBOUNCE_CYCLES(D), .AUTO_CLEAR_CYCLES(AUTO1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .din(din),
    .s(u1_s), .r(u1_r), .state(u1_state), .lvl(u1_lvl), .expired(u1_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Behavioural model. lvl changes when the last D synchronised samples all
  // disagree with it; s goes out on every rise; r on a fall while set, or
  // AUTO edges after the s edge; state is an srff fed by the model's pulses.
  // ---------------------------------------------------------------------
  bit m_meta, m_sync, m_lvl;
  bit m_win [D];
  int m_cyc;
  bit m_s [2];
  bit m_r [2];
  bit m_state [2];
  bit m_exp [2];
  bit m_inset [2];
  int m_setcyc [2];

  function automatic int auto_of(input int i);
    return (i == 0) ? 0 : AUTO1;
  endfunction

  task automatic model_step();
    bit all_diff;
    bit old_lvl;
    bit rise;
    bit fall;
    if (rst) begin
      m_meta = 1'b0;
      m_sync = 1'b0;
      m_lvl  = 1'b0;
      for (int k = 0; k < D; k++) m_win[k] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_s[i] = 0; m_r[i] = 0; m_state[i] = 0; m_exp[i] = 0; m_inset[i] = 0;
      end
    end else begin
      m_cyc++;
      for (int i = 0; i < 2; i++)
        m_state[i] = m_s[i] ? 1'b1 : (m_r[i] ? 1'b0 : m_state[i]);
      for (int k = 0; k < D-1; k++) m_win[k] = m_win[k+1];
      m_win[D-1] = m_sync;
      all_diff = 1'b1;
      for (int k = 0; k < D; k++) if (m_win[k] == m_lvl) all_diff = 1'b0;
      old_lvl = m_lvl;
      if (all_diff) m_lvl = m_sync;
      rise = !old_lvl && m_lvl;
      fall = old_lvl && !m_lvl;
      for (int i = 0; i < 2; i++) begin
        m_s[i] = rise;
        m_r[i] = 1'b0;
        if (m_inset[i]) begin
          if (fall) begin
            m_r[i] = 1'b1;
            m_inset[i] = 1'b0;
          end else if (auto_of(i) != 0 && m_cyc == m_setcyc[i] + auto_of(i)) begin
            m_r[i] = 1'b1;
            m_inset[i] = 1'b0;
            m_exp[i] = 1'b1;
          end
        end
        if (fall) m_exp[i] = 1'b0;
        if (rise) begin
          m_inset[i]  = 1'b1;
          m_setcyc[i] = m_cyc;
        end
      end
      m_sync = m_meta;
      m_meta = din;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [4:0] dv;
    logic [4:0] mv;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        dv = (i == 0) ? {u0_s, u0_r, u0_state, u0_lvl, u0_exp}
                      : {u1_s, u1_r, u1_state, u1_lvl, u1_exp};
        mv = {m_s[i], m_r[i], m_state[i], m_lvl, m_exp[i]};
        total++;
        if (dv !== mv) begin
          bad++;
          $display("FAIL model_cmp u%0d at %0t: actual{s,r,state,lvl,exp}=%b required=%b",
                   i, $time, dv, mv);
        end
      end
    end
  end

  initial begin
    int len;
    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    m_cyc  = 0;
    rst    = 1'b1;
    din    = 1'b0;

    // Reset state.
    ticks(3);
    chk("rst_s", u0_s, 1'b0);
    chk("rst_state", u0_state, 1'b0);
    chk("rst_exp", u1_exp, 1'b0);

    // Rise before edge 1: s after edge 6, state from edge 7; u1 auto-clears at 16.
    rst = 1'b0;
    din = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 5)  chk("lat_s_early", u0_s, 1'b0);
      if (e == 6) begin
        chk("lat_s", u0_s, 1'b1);
        chk("lat_lvl", u0_lvl, 1'b1);
        chk("lat_state_pre", u0_state, 1'b0);
        chk("model_s_pin", m_s[0], 1'b1);
      end
      if (e == 7) begin
        chk("lat_s_one_cycle", u0_s, 1'b0);
        chk("lat_state", u0_state, 1'b1);
      end
      if (e == 16) begin
        chk("auto_r", u1_r, 1'b1);
        chk("auto_exp", u1_exp, 1'b1);
        chk("noauto_r", u0_r, 1'b0);
        chk("model_auto_pin", m_r[1], 1'b1);
      end
      if (e == 17) begin
        chk("auto_state", u1_state, 1'b0);
        chk("noauto_state", u0_state, 1'b1);
      end
    end

    // Fall: r on u0, silent exit from EXPIRED on u1.
    din = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 6) begin
        chk("fall_r", u0_r, 1'b1);
        chk("exp_fall_no_r", u1_r, 1'b0);
        chk("exp_clear", u1_exp, 1'b0);
      end
      if (e == 7) chk("fall_state", u0_state, 1'b0);
    end

    // Glitches of 3 samples never reach lvl.
    for (int g = 0; g < 5; g++) begin
      din = 1'b1; ticks(3);
      din = 1'b0; ticks(3);
    end
    ticks(6);
    chk("glitch_lvl", u0_lvl, 1'b0);

    // Rearm on u1, then lvl falls on the same edge the timeout would fire.
    din = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      if (e == 6)  chk("rearm_s", u1_s, 1'b1);
      if (e == 10) din = 1'b0;
      if (e == 16) begin
        chk("tie_r", u1_r, 1'b1);
        chk("tie_exp", u1_exp, 1'b0);
      end
      if (e == 17) chk("tie_state", u1_state, 1'b0);
    end
    ticks(8);

    // Reset while in SET with din held high.
    din = 1'b1;
    ticks(8);
    rst = 1'b1;
    for (int e = 0; e < 2; e++) begin
      tick();
      chk("midrst_s", u0_s, 1'b0);
      chk("midrst_state", u0_state, 1'b0);
      chk("midrst_lvl", u1_lvl, 1'b0);
    end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) chk("postrst_s_early", u0_s, 1'b0);
      if (e == 6) chk("postrst_s", u0_s, 1'b1);
      if (e == 7) chk("postrst_state", u1_state, 1'b1);
    end

    // Randomised runs, mixing bounces, long holds and occasional resets.
    for (int n = 0; n < 4000; n += len) begin
      din = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                        : int'($urandom_range(1, 6));
      ticks(len);
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        ticks(int'($urandom_range(1, 2)));
        rst = 1'b0;
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
